// File: rtl/cu_pkg.sv
// Shared types and constants for the hard-wired control sequencer: states,
// IR field positions, opcode/ALU encodings and the opcode classifier function.
package cu_pkg;

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, HALT} state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_IMM, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RA_MSB     = 26;
  localparam int RA_LSB     = 23;
  localparam int RB_MSB     = 22;
  localparam int RB_LSB     = 19;
  localparam int RC_MSB     = 18;
  localparam int RC_LSB     = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b00010;
  localparam logic [4:0] ALU_AND = 5'b01000;
  localparam logic [4:0] ALU_OR  = 5'b01001;
  localparam logic [4:0] ALU_ROR = 5'b01010;
  localparam logic [4:0] ALU_ROL = 5'b01011;
  localparam logic [4:0] ALU_SHR = 5'b01100;
  localparam logic [4:0] ALU_SHL = 5'b01101;
  localparam logic [4:0] ALU_MUL = 5'b01110;
  localparam logic [4:0] ALU_DIV = 5'b01111;

  typedef struct packed {
    op_class_e  cls;
    logic [4:0] alu;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [4:0] opcode);
    op_info_t info;
    info.cls = CLS_ILLEGAL;
    info.alu = '0;
    case (opcode)
      OP_ADD:  begin info.cls = CLS_ALU;    info.alu = ALU_ADD; end
      OP_SUB:  begin info.cls = CLS_ALU;    info.alu = ALU_SUB; end
      OP_AND:  begin info.cls = CLS_ALU;    info.alu = ALU_AND; end
      OP_OR:   begin info.cls = CLS_ALU;    info.alu = ALU_OR;  end
      OP_ROR:  begin info.cls = CLS_ALU;    info.alu = ALU_ROR; end
      OP_ROL:  begin info.cls = CLS_ALU;    info.alu = ALU_ROL; end
      OP_SHR:  begin info.cls = CLS_ALU;    info.alu = ALU_SHR; end
      OP_SHL:  begin info.cls = CLS_ALU;    info.alu = ALU_SHL; end
      OP_ADDI: begin info.cls = CLS_IMM;    info.alu = ALU_ADD; end
      OP_ANDI: begin info.cls = CLS_IMM;    info.alu = ALU_AND; end
      OP_ORI:  begin info.cls = CLS_IMM;    info.alu = ALU_OR;  end
      OP_MUL:  begin info.cls = CLS_MULDIV; info.alu = ALU_MUL; end
      OP_DIV:  begin info.cls = CLS_MULDIV; info.alu = ALU_DIV; end
      OP_NOP:  info.cls = CLS_NOP;
      OP_HALT: info.cls = CLS_HALT;
      default: info.cls = CLS_ILLEGAL;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classifier: maps the IR opcode field to an
// instruction class and the ALU operation code it requires.
module cu_decode
  import cu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  cls,
  output logic [4:0] alu
);

  op_info_t info;

  assign info = decode_op(opcode);
  assign cls  = info.cls;
  assign alu  = info.alu;

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired control unit: fetch T0-T2, decode in T3, execute T4-T6.
// Optional ILLEGAL_TRAP_EN: unlisted opcodes halt and raise `illegal`.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [31:0]         IR,
  output logic                PCout,
  output logic                Zlowout,
  output logic                ZHighout,
  output logic                MDRout,
  output logic                HIout,
  output logic                LOout,
  output logic                Cout,
  output logic                InPortout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic                ZHIin,
  output logic                ZLOin,
  output logic                Cin,
  output logic                IncPC,
  output logic                Read,
  output logic                branch_flag,
  output logic [OPW-1:0]      operation,
  output logic [NUM_REGS-1:0] enableReg,
  output logic [NUM_REGS-1:0] Rout,
`ifdef ILLEGAL_TRAP_EN
  output logic                illegal,
`endif
  output logic                halted
);

  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  state_e     state, next;
  op_class_e  cls;
  logic [4:0] alu;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign ra        = IR[RA_MSB:RA_LSB];
  assign rb        = IR[RB_MSB:RB_LSB];
  assign rc        = IR[RC_MSB:RC_LSB];
  assign unused_ir = ^IR[RC_LSB-1:0];

  cu_decode u_decode (
    .opcode (IR[OPCODE_MSB:OPCODE_LSB]),
    .cls    (cls),
    .alu    (alu)
  );

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    return ONE << (32'(idx) % NUM_REGS);
  endfunction

  always_ff @(posedge clk) begin
    if (clr) state <= RST;
    else     state <= next;
  end

  always_comb begin
    next        = state;
    PCout       = 1'b0;
    Zlowout     = 1'b0;
    ZHighout    = 1'b0;
    MDRout      = 1'b0;
    HIout       = 1'b0;
    LOout       = 1'b0;
    Cout        = 1'b0;
    InPortout   = 1'b0;
    MARin       = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    ZHIin       = 1'b0;
    ZLOin       = 1'b0;
    Cin         = 1'b0;
    IncPC       = 1'b0;
    Read        = 1'b0;
    branch_flag = 1'b0;
    operation   = '0;
    enableReg   = '0;
    Rout        = '0;
    halted      = 1'b0;
    case (state)
      RST: next = T0;
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1;
        next  = T1;
      end
      T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        next    = T2;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next   = T3;
      end
      // IR holds the freshly fetched instruction from here on, so T3 decodes.
      T3: begin
        case (cls)
          CLS_ALU, CLS_IMM, CLS_MULDIV: begin
            Rout = onehot(rb);
            Yin  = 1'b1;
            next = T4;
          end
          CLS_HALT: next = HALT;
`ifdef ILLEGAL_TRAP_EN
          CLS_ILLEGAL: next = HALT;
`else
          CLS_ILLEGAL: next = T0;
`endif
          default: next = T0;
        endcase
      end
      T4: begin
        ZLOin     = 1'b1;
        operation = OPW'(alu);
        if (cls == CLS_IMM) Cout = 1'b1;
        else                Rout = onehot(rc);
        if (cls == CLS_MULDIV) ZHIin = 1'b1;
        next = T5;
      end
      T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          LOin = 1'b1;
          next = T6;
        end else begin
          enableReg = onehot(ra);
          next      = T0;
        end
      end
      T6: begin
        ZHighout = 1'b1; HIin = 1'b1;
        next     = T0;
      end
      HALT: begin
        halted = 1'b1;
        next   = HALT;
      end
      default: next = RST;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (clr)                                   illegal <= 1'b0;
    else if (state == T3 && cls == CLS_ILLEGAL) illegal <= 1'b1;
  end
`endif

endmodule
